// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - round-robin arbiter multiplexing N packet FIFOs onto one packet sender
module packet_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4,
    parameter int GAP       = 2,
    parameter int MAX_HOLD  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          fifo_rempty,
    input  logic [N_PORTS*UWIDTH-1:0]   fifo_rdata,
    output logic [N_PORTS-1:0]          fifo_rinc,
    output logic [PTR_IN_SZ-1:0]        fifo_raddr_in,
    output logic                        ps_rempty,
    output logic [UWIDTH-1:0]           ps_rdata,
    input  logic                        ps_rinc,
    input  logic [PTR_IN_SZ-1:0]        ps_raddr_in,
    output logic [N_PORTS-1:0]          grant,
    output logic                        timeout
);

    localparam int SEL_W  = $clog2(N_PORTS);
    localparam int HOLD_W = 8;
    localparam int GAP_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   next_ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               hold_limit;

    // Cyclic search from rr_ptr; scanning offsets high-to-low lets the nearest port win.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= N_PORTS) begin
                j = j - N_PORTS;
            end
            if (!fifo_rempty[j]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(j);
            end
        end
    end

    assign next_ptr   = (sel == SEL_W'(N_PORTS - 1)) ? '0 : sel + 1'b1;
    assign hold_limit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            grant    <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        sel      <= pick_idx;
                        grant    <= N_PORTS'(1) << pick_idx;
                        hold_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (ps_rinc || hold_limit) begin
                        // A pop on the limit cycle counts as a normal release, not a timeout.
                        timeout <= ~ps_rinc;
                        rr_ptr  <= next_ptr;
                        grant   <= '0;
                        gap_cnt <= '0;
                        state   <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data path follows the owner directly so the sender sees FIFO flags without extra latency.
    always_comb begin
        ps_rempty = 1'b1;
        ps_rdata  = '0;
        fifo_rinc = '0;
        if (state == BUSY) begin
            ps_rempty      = fifo_rempty[sel];
            ps_rdata       = fifo_rdata[int'(sel)*UWIDTH +: UWIDTH];
            fifo_rinc[sel] = ps_rinc;
        end
    end

    assign fifo_raddr_in = ps_raddr_in;

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - directed self-checking bench for packet_arbiter
module tb_packet_arbiter;

    localparam int N_PORTS   = 4;
    localparam int UWIDTH    = 8;
    localparam int PTR_IN_SZ = 4;
    localparam int GAP       = 2;
    localparam int MAX_HOLD  = 64;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [N_PORTS-1:0]         fifo_rempty = 4'hF;
    logic [N_PORTS*UWIDTH-1:0]  fifo_rdata = {8'h33, 8'h22, 8'h0A, 8'h11};
    logic [N_PORTS-1:0]         fifo_rinc;
    logic [PTR_IN_SZ-1:0]       fifo_raddr_in;
    logic                       ps_rempty;
    logic [UWIDTH-1:0]          ps_rdata;
    logic                       ps_rinc = 1'b0;
    logic [PTR_IN_SZ-1:0]       ps_raddr_in = 4'd5;
    logic [N_PORTS-1:0]         grant;
    logic                       timeout;

    int checks = 0;
    int errors = 0;

    packet_arbiter #(
        .N_PORTS(N_PORTS), .UWIDTH(UWIDTH), .PTR_IN_SZ(PTR_IN_SZ),
        .GAP(GAP), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata),
        .fifo_rinc(fifo_rinc), .fifo_raddr_in(fifo_raddr_in),
        .ps_rempty(ps_rempty), .ps_rdata(ps_rdata),
        .ps_rinc(ps_rinc), .ps_raddr_in(ps_raddr_in),
        .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        while (grant == 4'b0000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, grant, exp);
    endtask

    task automatic pop(input string tag, input logic [3:0] exp);
        ps_rinc = 1'b1;
        #1;
        check(tag, fifo_rinc, exp);
        @(negedge clk);
        ps_rinc = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        logic [7:0] rr_data [5];
        int n;
        int bad;
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_data = '{8'h11, 8'h0A, 8'h22, 8'h33, 8'h11};

        #1;
        check("rst_grant", grant, 4'b0000);
        check("rst_ps_rempty", ps_rempty, 1'b1);
        check("rst_ps_rdata", ps_rdata, 8'h00);
        check("rst_fifo_rinc", fifo_rinc, 4'b0000);
        check("rst_timeout", timeout, 1'b0);
        check("rst_raddr", fifo_raddr_in, 4'd5);

        // Single request on port 1
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fifo_rempty = 4'b1101;
        @(negedge clk);
        check("single_grant", grant, 4'b0010);
        check("single_rdata", ps_rdata, 8'd10);
        check("single_rempty", ps_rempty, 1'b0);
        check("single_no_rinc", fifo_rinc, 4'b0000);
        check("busy_raddr", fifo_raddr_in, 4'd5);
        pop("single_rinc", 4'b0010);
        check("rel1_grant", grant, 4'b0000);
        fifo_rempty = 4'hF;
        ps_rinc = 1'b1;
        #1;
        check("rel_rinc_ignored", fifo_rinc, 4'b0000);
        check("rel_raddr", fifo_raddr_in, 4'd5);
        check("rel_ps_rempty", ps_rempty, 1'b1);
        @(negedge clk);
        check("rel2_grant", grant, 4'b0000);
        ps_rinc = 1'b0;
        @(negedge clk);
        ps_raddr_in = 4'd9;
        ps_rinc = 1'b1;
        #1;
        check("idle_rinc_ignored", fifo_rinc, 4'b0000);
        check("idle_raddr", fifo_raddr_in, 4'd9);
        @(negedge clk);
        ps_rinc = 1'b0;
        check("idle_stays", grant, 4'b0000);
        check("idle_no_timeout", timeout, 1'b0);

        // Round-robin rotation with all ports non-empty
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fifo_rempty = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (grant == 4'b0000 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("rr_grant", grant, rr_exp[k]);
            check("rr_rdata", ps_rdata, rr_data[k]);
            if (k > 0) check("rr_gap", n, GAP + 1);
            repeat (6) @(negedge clk);
            pop("rr_rinc", rr_exp[k]);
        end

        // Watchdog on port 2 (rr_ptr now 1); port 2 goes empty mid-grant
        fifo_rempty = 4'b1011;
        wait_grant("wd_grant", 4'b0100);
        fifo_rempty = 4'b1100;
        #1;
        check("kept_grant", grant, 4'b0100);
        check("kept_rempty", ps_rempty, 1'b1);
        n = 0;
        bad = 0;
        while (grant == 4'b0100 && n < 200) begin
            if (timeout !== 1'b0 || fifo_rinc !== 4'b0000) bad++;
            @(negedge clk);
            n++;
        end
        check("wd_hold_cycles", n, MAX_HOLD);
        check("wd_early_activity", bad, 0);
        check("wd_timeout_pulse", timeout, 1'b1);
        @(negedge clk);
        check("wd_timeout_clear", timeout, 1'b0);
        wait_grant("wd_next_grant", 4'b0001);
        check("wd_next_rdata", ps_rdata, 8'h11);

        // Pop on the watchdog-limit cycle is a normal release
        repeat (MAX_HOLD - 1) @(negedge clk);
        check("limit_still_granted", grant, 4'b0001);
        pop("limit_rinc", 4'b0001);
        check("limit_no_timeout", timeout, 1'b0);
        check("limit_grant_drop", grant, 4'b0000);

        // Reset during BUSY on port 1 with rr_ptr at 2
        fifo_rempty = 4'b1101;
        wait_grant("pre_rst_grant_a", 4'b0010);
        pop("pre_rst_rinc", 4'b0010);
        wait_grant("pre_rst_grant_b", 4'b0010);
        ps_rinc = 1'b1;
        rst = 1'b0;
        #1;
        check("mid_rst_grant", grant, 4'b0000);
        check("mid_rst_rempty", ps_rempty, 1'b1);
        check("mid_rst_rinc", fifo_rinc, 4'b0000);
        check("mid_rst_rdata", ps_rdata, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        ps_rinc = 1'b0;
        fifo_rempty = 4'b0101;
        wait_grant("post_rst_grant", 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
